// File: rtl/mmio_port_uart.sv
// Memory-mapped responder on the processor data bus. It provides an output port,
// a synchronized input port with change flag, and a FIFO-fed 8N1 transmitter.
module mmio_port_uart #(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TxSerial
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  COUNT_MAX = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t         txState;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic [7:0]       shiftReg;
  logic [2:0]       bitCnt;
  logic [BAUD_W-1:0] baudCnt;
  logic [7:0]       pinMeta, pinSync, pinPrev;
  logic             pinChanged, txOverflow;

  logic [1:0]  regSel;
  logic        writeEn, statusWr, pushReq, pushOk, popReq;
  logic        fifoEmpty, fifoFull, baudWrap, txBusy;
  logic [31:0] statusWord;
  logic        unusedAddrBits;

  assign Hit            = (Address[31:4] == BASE_ADDRESS[31:4]);
  assign regSel         = Address[3:2];
  assign unusedAddrBits = ^Address[1:0];
  assign writeEn        = Hit && MemWrite;
  assign statusWr       = writeEn && (regSel == 2'd3);
  assign pushReq        = writeEn && (regSel == 2'd2);
  assign fifoEmpty      = (fifoCount == '0);
  assign fifoFull       = (fifoCount == COUNT_MAX);
  assign baudWrap       = (baudCnt == BAUD_LAST);
  assign txBusy         = (txState != IDLE);
  // The transmitter takes a byte when idle, or straight out of STOP for gapless frames.
  assign popReq = !fifoEmpty && ((txState == IDLE) || ((txState == STOP) && baudWrap));
  assign pushOk = pushReq && (!fifoFull || popReq);

  assign statusWord = {22'b0, txOverflow, pinChanged, 2'b0, 3'(fifoCount),
                       fifoEmpty, fifoFull, txBusy};

  always_comb begin
    ReadData = 32'b0;
    if (Hit && MemRead) begin
      case (regSel)
        2'd0:    ReadData = PortOut;
        2'd1:    ReadData = {24'b0, pinSync};
        2'd3:    ReadData = statusWord;
        default: ReadData = 32'b0;
      endcase
    end
  end

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut    <= 32'b0;
      pinMeta    <= 8'b0;
      pinSync    <= 8'b0;
      pinPrev    <= 8'b0;
      pinChanged <= 1'b0;
      txOverflow <= 1'b0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifoCount  <= '0;
    end else begin
      pinMeta <= PortIn;
      pinSync <= pinMeta;
      pinPrev <= pinSync;
      if (writeEn && (regSel == 2'd0)) PortOut <= WriteData;
      // A new event beats a simultaneous write-one-to-clear so no change is lost.
      if (pinSync != pinPrev)             pinChanged <= 1'b1;
      else if (statusWr && WriteData[8])  pinChanged <= 1'b0;
      if (pushReq && !pushOk)             txOverflow <= 1'b1;
      else if (statusWr && WriteData[9])  txOverflow <= 1'b0;
      if (pushOk) wrPtr <= nextPtr(wrPtr);
      if (popReq) rdPtr <= nextPtr(rdPtr);
      fifoCount <= fifoCount + CNT_W'(pushOk) - CNT_W'(popReq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txState  <= IDLE;
      TxSerial <= 1'b1;
      shiftReg <= 8'b0;
      bitCnt   <= 3'd0;
      baudCnt  <= '0;
    end else begin
      case (txState)
        IDLE: begin
          if (popReq) begin
            txState  <= START;
            TxSerial <= 1'b0;
            shiftReg <= fifoMem[rdPtr];
            baudCnt  <= '0;
          end
        end
        START: begin
          if (baudWrap) begin
            baudCnt  <= '0;
            txState  <= DATA;
            TxSerial <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              bitCnt   <= 3'd0;
              txState  <= STOP;
              TxSerial <= 1'b1;
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              TxSerial <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (popReq) begin
              txState  <= START;
              TxSerial <= 1'b0;
              shiftReg <= fifoMem[rdPtr];
            end else begin
              txState <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: txState <= IDLE;
      endcase
    end
  end
endmodule
